mem_stage: RTL and testbench

//  Memory-access pipeline stage between EX and WB of the LoongArch core.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: bus geometry, forwarding field positions
// and the one-hot bit positions of the load-op vector.
package mem_stage_pkg;

    localparam int unsigned MS_BUS_WD  = 203;
    localparam int unsigned MS_RES_LSB = 32;

    // Register-write fields carried in the EX payload; only MS forwarding reads them.
    localparam int unsigned DEST_LSB  = 64;
    localparam int unsigned GR_WE_BIT = 69;

    // es_ld_op is one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
    localparam int unsigned LD_W  = 4;
    localparam int unsigned LD_H  = 3;
    localparam int unsigned LD_HU = 2;
    localparam int unsigned LD_B  = 1;
    localparam int unsigned LD_BU = 0;

    typedef logic [4:0] ld_op_t;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MS/WB pipeline link as seen by the MEM stage, plus the data-SRAM response
// and the forwarding outputs towards ID.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned BUS_WD = MS_BUS_WD
) ();

    logic              es_to_ms_valid;
    logic [BUS_WD-1:0] es_to_ms_bus;
    ld_op_t            es_ld_op;
    logic [1:0]        es_addr_lo;
    logic              es_mem_req;
    logic              es_ex;
    logic              es_req_orphan;
    logic              ms_allowin;

    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [BUS_WD-1:0] ms_to_ws_bus;

    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              flush;

    logic              ms_fwd_valid;
    logic [4:0]        ms_fwd_dest;
    logic [31:0]       ms_fwd_result;
    logic              ms_fwd_block;
    logic              ms_ex_pending;

    // MEM stage side
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, es_ld_op, es_addr_lo, es_mem_req,
               es_ex, es_req_orphan, ws_allowin, data_sram_data_ok,
               data_sram_rdata, flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_valid,
               ms_fwd_dest, ms_fwd_result, ms_fwd_block, ms_ex_pending
    );

    // Surrounding pipeline (EX, WB, ID, SRAM bridge)
    modport master (
        output es_to_ms_valid, es_to_ms_bus, es_ld_op, es_addr_lo, es_mem_req,
               es_ex, es_req_orphan, ws_allowin, data_sram_data_ok,
               data_sram_rdata, flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_valid,
               ms_fwd_dest, ms_fwd_result, ms_fwd_block, ms_ex_pending
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/half of the SRAM word and
// sign- or zero-extends it according to the one-hot load op.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  ld_op_t      ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[{addr_lo, 3'b000} +: 8];
        half_v = raw[{addr_lo[1], 4'b0000} +: 16];

        result = raw;
        if (ld_op[LD_B]) begin
            result = ext8(byte_v, 1'b1);
        end else if (ld_op[LD_BU]) begin
            result = ext8(byte_v, 1'b0);
        end else if (ld_op[LD_H]) begin
            result = ext16(half_v, 1'b1);
        end else if (ld_op[LD_HU]) begin
            result = ext16(half_v, 1'b0);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for its data-SRAM
// response, aligns load data into the result field and hands off to WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned BUS_WD  = MS_BUS_WD,
    parameter int unsigned RES_LSB = MS_RES_LSB
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave pif
);

    logic              ms_valid;
    logic [BUS_WD-1:0] ms_bus;
    ld_op_t            ms_ld_op;
    logic [1:0]        ms_addr_lo;
    logic              ms_mem_req;
    logic              ms_ex;

    logic              buf_valid;
    logic [31:0]       data_buf;
    logic [1:0]        cancel_cnt;
    logic [1:0]        cancel_nxt;

    logic              own_data_ok;
    logic              ms_ready_go;
    logic              ms_allowin;
    logic              ms_to_ws_valid;
    logic              retire;
    logic              capture;
    logic              buf_load;
    logic              kill_pending;
    logic [31:0]       raw_data;
    logic [31:0]       load_result;
    logic [BUS_WD-1:0] out_bus;
    logic              fwd_valid;

    // A response while cancel_cnt is non-zero answers a request of a flushed instruction.
    assign own_data_ok    = pif.data_sram_data_ok & (cancel_cnt == 2'd0);
    assign ms_ready_go    = ~ms_mem_req | ms_ex | buf_valid | own_data_ok;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & pif.ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~pif.flush;
    assign retire         = ms_to_ws_valid & pif.ws_allowin;
    assign capture        = pif.es_to_ms_valid & ms_allowin & ~pif.flush;
    assign buf_load       = ms_valid & own_data_ok & ~buf_valid & ~pif.flush & ~retire;

    // The MS request is still unanswered only if neither buffered nor answered this cycle.
    assign kill_pending   = ms_valid & ms_mem_req & ~buf_valid & ~own_data_ok;

    always_comb begin
        cancel_nxt = cancel_cnt;
        if (pif.data_sram_data_ok && cancel_cnt != 2'd0) begin
            cancel_nxt = cancel_nxt - 2'd1;
        end
        if (pif.flush) begin
            cancel_nxt = cancel_nxt + {1'b0, kill_pending} + {1'b0, pif.es_req_orphan};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            buf_valid  <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            if (pif.flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= pif.es_to_ms_valid;
            end

            if (capture || pif.flush || retire) begin
                buf_valid <= 1'b0;
            end else if (buf_load) begin
                buf_valid <= 1'b1;
            end

            cancel_cnt <= cancel_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            ms_bus     <= pif.es_to_ms_bus;
            ms_ld_op   <= pif.es_ld_op;
            ms_addr_lo <= pif.es_addr_lo;
            ms_mem_req <= pif.es_mem_req;
            ms_ex      <= pif.es_ex;
        end
        if (buf_load) begin
            data_buf <= pif.data_sram_rdata;
        end
    end

    assign raw_data = buf_valid ? data_buf : pif.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .ld_op   (ms_ld_op),
        .addr_lo (ms_addr_lo),
        .raw     (raw_data),
        .result  (load_result)
    );

    // Excepting loads never got data, so their payload passes through untouched.
    always_comb begin
        out_bus = ms_bus;
        if ((|ms_ld_op) && !ms_ex) begin
            out_bus[RES_LSB +: 32] = load_result;
        end
    end

    assign fwd_valid = ms_valid & ms_bus[GR_WE_BIT] & ~ms_ex;

    assign pif.ms_allowin     = ms_allowin;
    assign pif.ms_to_ws_valid = ms_to_ws_valid;
    assign pif.ms_to_ws_bus   = out_bus;
    assign pif.ms_fwd_valid   = fwd_valid;
    assign pif.ms_fwd_dest    = ms_bus[DEST_LSB +: 5];
    assign pif.ms_fwd_result  = out_bus[RES_LSB +: 32];
    assign pif.ms_fwd_block   = fwd_valid & (|ms_ld_op) & ~ms_ready_go;
    assign pif.ms_ex_pending  = ms_valid & ms_ex;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores push expected WB payloads,
// a negedge monitor pops and compares on every WB handshake.
module tb_mem_stage;

    localparam int unsigned BW = 203;

    logic clk;
    logic reset;

    mem_stage_if #(.BUS_WD(BW)) pif ();

    mem_stage #(.BUS_WD(BW), .RES_LSB(32)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  lo;
        logic [31:0] rd;
        logic [31:0] res;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bench-side payload layout: pc[31:0], result[63:32], dest[68:64], gr_we[69].
    function automatic logic [BW-1:0] mk_bus(input logic [31:0] pc, input logic [4:0] dest,
                                            input logic [31:0] res);
        logic [BW-1:0] b;
        b = '0;
        b[31:0]    = pc;
        b[63:32]   = res;
        b[68:64]   = dest;
        b[69]      = 1'b1;
        b[202:171] = ~pc;
        return b;
    endfunction

    function automatic logic [BW-1:0] with_res(input logic [BW-1:0] b, input logic [31:0] res);
        logic [BW-1:0] e;
        e = b;
        e[63:32] = res;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && pif.ms_to_ws_valid && pif.ws_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected actual=%h expected=none", pif.ms_to_ws_bus);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                if (pif.ms_to_ws_bus !== e) begin
                    errors++;
                    $display("FAIL wb_bus actual=%h expected=%h", pif.ms_to_ws_bus, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pif.es_to_ms_valid    = 1'b0;
        pif.es_to_ms_bus      = '0;
        pif.es_ld_op          = '0;
        pif.es_addr_lo        = '0;
        pif.es_mem_req        = 1'b0;
        pif.es_ex             = 1'b0;
        pif.es_req_orphan     = 1'b0;
        pif.ws_allowin        = 1'b1;
        pif.data_sram_data_ok = 1'b0;
        pif.data_sram_rdata   = '0;
        pif.flush             = 1'b0;
    endtask

    task automatic issue(input logic [BW-1:0] b, input logic [4:0] op, input logic [1:0] lo,
                         input logic req, input logic ex);
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = b;
        pif.es_ld_op       = op;
        pif.es_addr_lo     = lo;
        pif.es_mem_req     = req;
        pif.es_ex          = ex;
        chk("allowin_at_issue", {31'd0, pif.ms_allowin}, 32'd1);
        step();
        pif.es_to_ms_valid = 1'b0;
        pif.es_ld_op       = '0;
        pif.es_mem_req     = 1'b0;
        pif.es_ex          = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] b;

        vt[0] = '{5'b00010, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
        vt[1] = '{5'b00001, 2'd1, 32'h0000_9A00, 32'h0000_009A};
        vt[2] = '{5'b01000, 2'd0, 32'h1234_8765, 32'hFFFF_8765};
        vt[3] = '{5'b01000, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF};
        vt[4] = '{5'b00010, 2'd0, 32'h0000_007F, 32'h0000_007F};
        vt[5] = '{5'b00000, 2'd0, 32'hFFFF_FFFF, 32'hABCD_0123};

        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_to_ws_valid", {31'd0, pif.ms_to_ws_valid}, 32'd0);
        chk("rst_allowin",     {31'd0, pif.ms_allowin},     32'd1);
        chk("rst_fwd_valid",   {31'd0, pif.ms_fwd_valid},   32'd0);
        chk("rst_ex_pending",  {31'd0, pif.ms_ex_pending},  32'd0);
        reset = 1'b0;
        step();

        // Table: data_ok one cycle after capture, same-cycle retire.
        for (int i = 0; i < 6; i++) begin
            b = mk_bus(32'h1c00_0000 + 32'(i * 4), 5'(i + 4), 32'hABCD_0123);
            exp_q.push_back(with_res(b, vt[i].res));
            issue(b, vt[i].op, vt[i].lo, 1'b1, 1'b0);
            chk("wait_no_data", {31'd0, pif.ms_to_ws_valid}, 32'd0);
            pif.data_sram_data_ok = 1'b1;
            pif.data_sram_rdata   = vt[i].rd;
            #1;
            chk("same_cycle_valid", {31'd0, pif.ms_to_ws_valid}, 32'd1);
            step();
            pif.data_sram_data_ok = 1'b0;
        end
        chk("empty_after_table", {31'd0, pif.ms_to_ws_valid}, 32'd0);

        // ld_hu with a late response: stall visible to ID.
        b = mk_bus(32'h1c00_0100, 5'd7, 32'h0);
        exp_q.push_back(with_res(b, 32'h0000_8001));
        issue(b, 5'b00100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("late_no_valid", {31'd0, pif.ms_to_ws_valid}, 32'd0);
            chk("late_fwd_block", {31'd0, pif.ms_fwd_block}, 32'd1);
            step();
        end
        pif.data_sram_data_ok = 1'b1;
        pif.data_sram_rdata   = 32'h8001_0000;
        #1;
        chk("late_fwd_unblock", {31'd0, pif.ms_fwd_block}, 32'd0);
        chk("late_fwd_result", pif.ms_fwd_result, 32'h0000_8001);
        step();
        pif.data_sram_data_ok = 1'b0;

        // ld_w completes while WB is stalled: data must survive in the buffer.
        b = mk_bus(32'h1c00_0200, 5'd9, 32'h0);
        exp_q.push_back(with_res(b, 32'hDEAD_BEEF));
        issue(b, 5'b10000, 2'd0, 1'b1, 1'b0);
        pif.ws_allowin        = 1'b0;
        pif.data_sram_data_ok = 1'b1;
        pif.data_sram_rdata   = 32'hDEAD_BEEF;
        step();
        pif.data_sram_data_ok = 1'b0;
        pif.data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("buf_hold_valid", {31'd0, pif.ms_to_ws_valid}, 32'd1);
        chk("buf_hold_result", pif.ms_fwd_result, 32'hDEAD_BEEF);
        chk("buf_hold_allowin", {31'd0, pif.ms_allowin}, 32'd0);
        step();
        pif.ws_allowin = 1'b1;
        step();

        // Flush with MS load outstanding plus an orphaned EX request.
        b = mk_bus(32'h1c00_0300, 5'd10, 32'h0);
        issue(b, 5'b10000, 2'd0, 1'b1, 1'b0);
        pif.flush         = 1'b1;
        pif.es_req_orphan = 1'b1;
        #1;
        chk("flush_no_valid", {31'd0, pif.ms_to_ws_valid}, 32'd0);
        step();
        pif.flush         = 1'b0;
        pif.es_req_orphan = 1'b0;
        chk("cancel_two", {30'd0, dut.cancel_cnt}, 32'd2);
        b = mk_bus(32'h1c00_0304, 5'd11, 32'h0);
        exp_q.push_back(with_res(b, 32'hCAFE_F00D));
        issue(b, 5'b10000, 2'd0, 1'b1, 1'b0);
        pif.data_sram_data_ok = 1'b1;
        pif.data_sram_rdata   = 32'h1111_1111;
        #1;
        chk("stale1_ignored", {31'd0, pif.ms_to_ws_valid}, 32'd0);
        step();
        pif.data_sram_rdata = 32'h2222_2222;
        #1;
        chk("stale2_ignored", {31'd0, pif.ms_to_ws_valid}, 32'd0);
        step();
        pif.data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("own_data_valid", {31'd0, pif.ms_to_ws_valid}, 32'd1);
        step();
        pif.data_sram_data_ok = 1'b0;
        chk("cancel_zero", {30'd0, dut.cancel_cnt}, 32'd0);

        // Flush in the same cycle as the MS load's own response.
        b = mk_bus(32'h1c00_0400, 5'd12, 32'h0);
        issue(b, 5'b10000, 2'd0, 1'b1, 1'b0);
        pif.flush             = 1'b1;
        pif.data_sram_data_ok = 1'b1;
        pif.data_sram_rdata   = 32'h3333_3333;
        #1;
        chk("flush_ok_no_valid", {31'd0, pif.ms_to_ws_valid}, 32'd0);
        step();
        pif.flush             = 1'b0;
        pif.data_sram_data_ok = 1'b0;
        chk("flush_ok_cancel", {30'd0, dut.cancel_cnt}, 32'd0);
        chk("flush_ok_fwd", {31'd0, pif.ms_fwd_valid}, 32'd0);

        // Excepting load without a request: passes straight through.
        b = mk_bus(32'h1c00_0500, 5'd13, 32'h55AA_55AA);
        exp_q.push_back(b);
        pif.data_sram_rdata = 32'h1234_5678;
        issue(b, 5'b10000, 2'd1, 1'b0, 1'b1);
        chk("ex_pending", {31'd0, pif.ms_ex_pending}, 32'd1);
        chk("ex_fwd_valid", {31'd0, pif.ms_fwd_valid}, 32'd0);
        chk("ex_valid", {31'd0, pif.ms_to_ws_valid}, 32'd1);
        step();
        chk("ex_pending_clear", {31'd0, pif.ms_ex_pending}, 32'd0);

        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
